// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divisor calculation used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int OSR      = 16;
    localparam int HALF_OSR = 8;
    localparam int DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Rounded clk_freq / (baud * osr).
    function automatic int uart_div(input int clk_freq, input int baud, input int osr);
        return (clk_freq + (baud * osr) / 2) / (baud * osr);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every DIV clocks, restarting at zero on reset.
module uart_baud_tick #(
    parameter int DIV = 163
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver (8-N-1, or 8-E-1 when UART_RX_PARITY_EN is defined)
// with receive-register-full handshake, framing and sticky overrun status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600,
    parameter int OSR      = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              RxD,
    input  logic              rdrf_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rdrf,
    output logic              fe,
    output logic              oe,
    output logic              pe
);

    localparam int         DIV       = uart_div(CLK_FREQ, BAUD, OSR);
    localparam logic [3:0] TICK_LAST = 4'(OSR - 1);
    localparam logic [3:0] HALF_LAST = 4'(HALF_OSR - 1);

    logic [1:0]        sync_reg;
    logic              rxs;
    logic              rxs_prev_reg;
    logic              fall;
    logic              tick;
    rx_state_t         state_reg, state_next;
    logic [3:0]        tick_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rdrf_reg, fe_reg, oe_reg;
    logic              half_done, tick_done;
    logic              cnt_clr, shift_en, par_en, load_en;
`ifdef UART_RX_PARITY_EN
    logic              par_bit_reg;
    logic              pe_reg;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    // Synchroniser idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_reg     <= 2'b11;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[0], RxD};
            rxs_prev_reg <= sync_reg[1];
        end
    end

    assign rxs       = sync_reg[1];
    assign fall      = rxs_prev_reg & ~rxs;
    assign half_done = tick && (tick_cnt_reg == HALF_LAST);
    assign tick_done = tick && (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START:  if (half_done) state_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (tick_done && (bit_cnt_reg == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (tick_done) state_next = ST_STOP;
`endif
            ST_STOP:   if (tick_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        load_en  = 1'b0;
        case (state_reg)
            ST_IDLE:   cnt_clr  = fall;
            ST_START:  cnt_clr  = half_done;
            ST_DATA:   shift_en = tick_done;
            ST_PARITY: par_en   = tick_done;
            ST_STOP:   load_en  = tick_done;
            default:   ;
        endcase
    end

    // Tick counter wraps naturally at 16, so each bit sample lands 16 ticks after the last.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            if (cnt_clr) begin
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
            if (shift_en) begin
                shift_reg   <= {rxs, shift_reg[DATA_W-1:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            par_bit_reg <= 1'b0;
            pe_reg      <= 1'b0;
        end else begin
            if (par_en) par_bit_reg <= rxs;
            if (load_en && !(rdrf_reg && !rdrf_clr)) pe_reg <= ^{shift_reg, par_bit_reg};
        end
    end
    assign pe = pe_reg;
`else
    assign pe = 1'b0;
`endif

    // A load with rdrf still set and no read this cycle drops the byte and flags overrun.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rx_data_reg <= '0;
            rdrf_reg    <= 1'b0;
            fe_reg      <= 1'b0;
            oe_reg      <= 1'b0;
        end else if (load_en) begin
            if (rdrf_reg && !rdrf_clr) begin
                oe_reg <= 1'b1;
            end else begin
                rx_data_reg <= shift_reg;
                fe_reg      <= ~rxs;
                rdrf_reg    <= 1'b1;
                if (rdrf_clr) oe_reg <= 1'b0;
            end
        end else if (rdrf_clr) begin
            rdrf_reg <= 1'b0;
            oe_reg   <= 1'b0;
        end
    end

    assign rx_data = rx_data_reg;
    assign rdrf    = rdrf_reg;
    assign fe      = fe_reg;
    assign oe      = oe_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a fast bit rate (DIV = 10, 160 clocks per bit);
// covers the parity frames too when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       RxD = 1'b1;
    logic       rdrf_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rdrf, fe, oe, pe;

    int n_vec = 0;
    int n_err = 0;

    uart_rx #(.CLK_FREQ(25_000_000), .BAUD(156_250), .OSR(16)) dut (
        .clk      (clk),
        .clr      (clr),
        .RxD      (RxD),
        .rdrf_clr (rdrf_clr),
        .rx_data  (rx_data),
        .rdrf     (rdrf),
        .fe       (fe),
        .oe       (oe),
        .pe       (pe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic use_par, input logic par);
        @(posedge clk); #1;
        $display("tx frame data=0x%02h stop=%0b parity=%0b/%0b", d, stop, use_par, par);
        RxD = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            wait_bits(1);
        end
        if (use_par) begin
            RxD = par;
            wait_bits(1);
        end
        RxD = stop;
        wait_bits(1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 rdrf_clr = 1'b1;
        @(posedge clk); #1 rdrf_clr = 1'b0;
        $display("rdrf_clr pulse");
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        wait_bits(n);
    endtask

    initial begin
        logic [7:0] abort_byte;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rdrf", {7'd0, rdrf}, 8'h00);
        check("rst_fe", {7'd0, fe}, 8'h00);
        check("rst_oe", {7'd0, oe}, 8'h00);
        check("rst_pe", {7'd0, pe}, 8'h00);
        @(posedge clk); #1 clr = 1'b1;
        idle(2);

        // 0x55, good stop
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("b55_rx_data", rx_data, 8'h55);
        check("b55_rdrf", {7'd0, rdrf}, 8'h01);
        check("b55_fe", {7'd0, fe}, 8'h00);
        check("b55_oe", {7'd0, oe}, 8'h00);
        check("b55_pe", {7'd0, pe}, 8'h00);
        pulse_clr();
        @(negedge clk);
        check("b55_clr_rdrf", {7'd0, rdrf}, 8'h00);
        check("b55_clr_data", rx_data, 8'h55);

        // 4-tick low glitch is a false start
        @(posedge clk); #1 RxD = 1'b0;
        repeat (40) @(posedge clk);
        #1 RxD = 1'b1;
        $display("tx glitch 40 clocks");
        idle(12);
        @(negedge clk);
        check("glitch_rdrf", {7'd0, rdrf}, 8'h00);
        check("glitch_data", rx_data, 8'h55);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("b3c_rx_data", rx_data, 8'h3C);
        check("b3c_rdrf", {7'd0, rdrf}, 8'h01);
        check("b3c_fe", {7'd0, fe}, 8'h00);
        pulse_clr();

        // Break: stop bit low, line held low afterwards
        idle(1);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ba3_rx_data", rx_data, 8'hA3);
        check("ba3_rdrf", {7'd0, rdrf}, 8'h01);
        check("ba3_fe", {7'd0, fe}, 8'h01);
        pulse_clr();
        wait_bits(20);
        @(negedge clk);
        check("brk_rdrf", {7'd0, rdrf}, 8'h00);
        check("brk_data", rx_data, 8'hA3);
        idle(3);
        @(negedge clk);
        check("brk_release_rdrf", {7'd0, rdrf}, 8'h00);

        // Overrun: second byte dropped
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("ovr_rx_data", rx_data, 8'h11);
        check("ovr_rdrf", {7'd0, rdrf}, 8'h01);
        check("ovr_oe", {7'd0, oe}, 8'h01);
        check("ovr_fe", {7'd0, fe}, 8'h00);
        pulse_clr();
        @(negedge clk);
        check("ovr_clr_rdrf", {7'd0, rdrf}, 8'h00);
        check("ovr_clr_oe", {7'd0, oe}, 8'h00);

        // Reset during data bit 3, line then left idle
        abort_byte = 8'h5A;
        @(posedge clk); #1;
        $display("tx aborted frame data=0x%02h", abort_byte);
        RxD = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 3; i++) begin
            RxD = abort_byte[i];
            wait_bits(1);
        end
        RxD = abort_byte[3];
        repeat (BIT / 2) @(posedge clk);
        #1 clr = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rdrf", {7'd0, rdrf}, 8'h00);
        check("mid_rst_fe", {7'd0, fe}, 8'h00);
        check("mid_rst_oe", {7'd0, oe}, 8'h00);
        check("mid_rst_pe", {7'd0, pe}, 8'h00);
        @(posedge clk); #1 clr = 1'b1;
        idle(12);
        @(negedge clk);
        check("mid_rst_noload", {7'd0, rdrf}, 8'h00);

        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        check("b7e_rx_data", rx_data, 8'h7E);
        check("b7e_rdrf", {7'd0, rdrf}, 8'h01);
        check("b7e_fe", {7'd0, fe}, 8'h00);
        check("b7e_oe", {7'd0, oe}, 8'h00);
        pulse_clr();

`ifdef UART_RX_PARITY_EN
        idle(1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check("par_ok_data", rx_data, 8'h07);
        check("par_ok_pe", {7'd0, pe}, 8'h00);
        check("par_ok_rdrf", {7'd0, rdrf}, 8'h01);
        pulse_clr();
        idle(1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        check("par_bad_data", rx_data, 8'h07);
        check("par_bad_pe", {7'd0, pe}, 8'h01);
        check("par_bad_fe", {7'd0, fe}, 8'h00);
        pulse_clr();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
